// File: rtl/vga_fb_arbiter_pkg.sv
// rtl/vga_fb_arbiter_pkg.sv - arbiter state encodings and framebuffer constants
package vga_fb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOST  = 2'd2
    } arb_state_e;

    localparam int FB_WORDS_DEFAULT = 307200;

    // RGB444 fields inside a pixel word; bits [15:12] are unused
    localparam int RGB_B_LSB   = 0;
    localparam int RGB_G_LSB   = 4;
    localparam int RGB_R_LSB   = 8;
    localparam int RGB_FIELD_W = 4;

endpackage

// File: rtl/vga_fb_arbiter_pixel_fifo.sv
// rtl/vga_fb_arbiter_pixel_fifo.sv - synchronous prefetch FIFO with flush and level
module vga_fb_arbiter_pixel_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter, VGA prefetch vs host; VGA_FB_STATS_EN adds underflow_cnt
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 16,
    parameter int FB_WORDS   = FB_WORDS_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_STATS_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TOT_W = LVL_W + 1;

    // state_q is the operation currently on the RAM bus
    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, fetch_base;
    logic              fetch_v2_q, fetch_v2_d;
    logic              host_ack_q, host_ack_d;
    logic              ack_rd_q, ack_rd_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              underflow_q, underflow_d;

    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty;
    logic              fifo_push, fifo_pop;
    logic [TOT_W-1:0]  fill_level;

    // A frame_start discards everything in flight, so the fill level restarts at zero
    assign fill_level = frame_start ? '0
                      : TOT_W'(fifo_level) + TOT_W'(state_q == ST_FETCH) + TOT_W'(fetch_v2_q);
    assign fetch_base = frame_start ? '0 : fetch_addr_q;
    assign fifo_push  = fetch_v2_q & ~frame_start;
    assign fifo_pop   = pix_rd & ~fifo_empty & ~frame_start;

    always_comb begin
        state_d      = ST_IDLE;
        fetch_addr_d = fetch_base;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        if (fill_level <= TOT_W'(LOW_WATER)) begin
            state_d = ST_FETCH;
        end else if (host_req && state_q != ST_HOST) begin
            state_d = ST_HOST;
        end else if (fill_level < TOT_W'(FIFO_DEPTH)) begin
            state_d = ST_FETCH;
        end

        case (state_d)
            ST_FETCH: begin
                mem_en_d     = 1'b1;
                mem_addr_d   = fetch_base;
                fetch_addr_d = (fetch_base == ADDR_W'(FB_WORDS - 1)) ? '0
                             : fetch_base + ADDR_W'(1);
            end
            ST_HOST: begin
                mem_en_d    = 1'b1;
                mem_we_d    = host_we;
                mem_addr_d  = host_addr;
                mem_wdata_d = host_we ? host_wdata : '0;
            end
            default: ;
        endcase

        fetch_v2_d  = (state_q == ST_FETCH) & ~frame_start;
        host_ack_d  = (state_q == ST_HOST);
        ack_rd_d    = (state_q == ST_HOST) & ~mem_we_q;
        underflow_d = underflow_q | (pix_rd & fifo_empty & ~frame_start);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= '0;
            fetch_v2_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            ack_rd_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_v2_q   <= fetch_v2_d;
            host_ack_q   <= host_ack_d;
            ack_rd_q     <= ack_rd_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            underflow_q  <= underflow_d;
        end
    end

    vga_fb_arbiter_pixel_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W)
    ) u_pixel_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .head      (pix_data),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign pix_valid  = ~fifo_empty;
    assign underflow  = underflow_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = ack_rd_q ? mem_rdata : '0;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef VGA_FB_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (frame_start) begin
            ucnt_d = '0;
        end else if (pix_rd && fifo_empty && ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int FB_W   = 64;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              pix_rd = 1'b0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              underflow;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef VGA_FB_STATS_EN
    logic [15:0]       underflow_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FB_WORDS   (FB_W),
        .FIFO_DEPTH (DEPTH),
        .LOW_WATER  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef VGA_FB_STATS_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    // RAM: unwritten words hold their own address as a recognisable pattern
    logic [DATA_W-1:0] ram [int];

    function automatic logic [DATA_W-1:0] ram_rd(input int a);
        if (ram.exists(a)) return ram[a];
        return DATA_W'(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[int'(mem_addr)] = mem_wdata;
            else        mem_rdata <= ram_rd(int'(mem_addr));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixels come out in raster order, fetches walk addresses in order
    int exp_pix   = 0;
    int exp_fetch = 0;
    int fetch_cnt = 0;
    bit exp_uf    = 1'b0;
    int exp_ucnt  = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_pix   = 0;
            exp_fetch = 0;
            fetch_cnt = 0;
            exp_uf    = 1'b0;
            exp_ucnt  = 0;
        end else begin
            check("underflow_sticky", 32'(underflow), 32'(exp_uf));
`ifdef VGA_FB_STATS_EN
            check("underflow_cnt", 32'(underflow_cnt), 32'(exp_ucnt));
`endif
            if (!pix_valid) check("pix_data_empty", 32'(pix_data), 32'h0);
            if (mem_en && !mem_we && int'(mem_addr) < FB_W) begin
                check("fetch_addr", 32'(mem_addr), 32'(exp_fetch));
                exp_fetch = (exp_fetch + 1) % FB_W;
                fetch_cnt++;
            end
            if (frame_start) begin
                exp_pix   = 0;
                exp_fetch = 0;
                exp_ucnt  = 0;
            end else if (pix_rd) begin
                if (pix_valid) begin
                    check("pix_order", 32'(pix_data), 32'(ram_rd(exp_pix)));
                    exp_pix = (exp_pix + 1) % FB_W;
                end else begin
                    exp_uf = 1'b1;
                    if (exp_ucnt < 16'hFFFF) exp_ucnt++;
                end
            end
        end
    end

    task automatic host_op(input bit we, input int addr, input logic [DATA_W-1:0] wd,
                           output logic [DATA_W-1:0] rd, output int lat);
        @(posedge clk); #1;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = ADDR_W'(addr);
        host_wdata = wd;
        lat        = 0;
        rd         = '0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (host_ack) begin
                rd = host_rdata;
                break;
            end
        end
        if (!host_ack) begin
            checks++;
            errors++;
            $display("FAIL host_ack_timeout: no ack after %0d cycles, addr %0d", lat, addr);
        end
        host_req = 1'b0;
    endtask

    typedef struct {
        bit                we;
        int                addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t              vecs [8];
    logic [DATA_W-1:0] host_model [int];
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] wd;
    int                lat;
    int                a;

    initial begin
        vecs[0] = '{1'b1, 100, 16'h0ABC, 16'h0000};
        vecs[1] = '{1'b0, 100, 16'h0000, 16'h0ABC};
        vecs[2] = '{1'b1, 200, 16'h1234, 16'h0000};
        vecs[3] = '{1'b1, 201, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b0, 200, 16'h0000, 16'h1234};
        vecs[5] = '{1'b0, 201, 16'h0000, 16'hFFFF};
        vecs[6] = '{1'b0, 300, 16'h0000, 16'h012C};
        vecs[7] = '{1'b0, 100, 16'h0000, 16'h0ABC};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_pix_data", 32'(pix_data), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_host_ack", 32'(host_ack), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
`ifdef VGA_FB_STATS_EN
        check("rst_underflow_cnt", 32'(underflow_cnt), 32'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle fill: exactly DEPTH fetches, then the bus goes quiet
        repeat (40) @(negedge clk);
        check("fill_fetch_count", 32'(fetch_cnt), 32'(DEPTH));
        check("fill_mem_en_idle", 32'(mem_en), 32'h0);
        check("fill_pix_valid", 32'(pix_valid), 32'h1);

        // Host table with the FIFO full: every access acks two cycles after request
        for (int i = 0; i < 8; i++) begin
            host_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
            check($sformatf("host_lat_%0d", i), 32'(lat), 32'd2);
            if (!vecs[i].we) check($sformatf("host_rdata_%0d", i), 32'(rd), 32'(vecs[i].exp_rdata));
        end

        // Host contending with a display that reads every cycle
        @(posedge clk); #1;
        pix_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_op(1'b0, 100, 16'h0, rd, lat);
            check($sformatf("contend_rdata_%0d", i), 32'(rd), 32'h0ABC);
        end
        repeat (20) @(posedge clk);
        #1;
        pix_rd = 1'b0;
        repeat (30) @(negedge clk);
        check("contend_no_underflow", 32'(underflow), 32'h0);

        // Random display reads with random host traffic; pops wrap the fetch address
        fork
            begin
                for (int c = 0; c < 400; c++) begin
                    @(posedge clk); #1;
                    pix_rd = ($urandom_range(0, 3) != 0);
                end
                @(posedge clk); #1;
                pix_rd = 1'b0;
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    a = 1000 + int'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) == 1) begin
                        wd = DATA_W'($urandom);
                        host_op(1'b1, a, wd, rd, lat);
                        host_model[a] = wd;
                    end else begin
                        host_op(1'b0, a, 16'h0, rd, lat);
                        check("rand_host_rdata", 32'(rd),
                              32'(host_model.exists(a) ? host_model[a] : DATA_W'(a)));
                    end
                end
            end
        join
        repeat (30) @(negedge clk);
        check("rand_no_underflow", 32'(underflow), 32'h0);

        // frame_start with reads in flight, coinciding with pix_rd
        @(posedge clk); #1;
        pix_rd = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        pix_rd      = 1'b1;
        @(negedge clk);
        check("fs_fifo_empty", 32'(pix_valid), 32'h0);
        check("fs_pix_data_zero", 32'(pix_data), 32'h0);
        check("fs_no_underflow", 32'(underflow), 32'h0);
        @(posedge clk); #1;
        pix_rd = 1'b0;
        @(negedge clk);
        check("uf_set", 32'(underflow), 32'h1);
`ifdef VGA_FB_STATS_EN
        check("uf_cnt_one", 32'(underflow_cnt), 32'h1);
`endif
        repeat (10) @(negedge clk);
        check("uf_sticky", 32'(underflow), 32'h1);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("uf_kept_by_fs", 32'(underflow), 32'h1);
`ifdef VGA_FB_STATS_EN
        check("uf_cnt_cleared", 32'(underflow_cnt), 32'h0);
`endif
        repeat (30) @(posedge clk);
        #1;
        pix_rd = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        pix_rd = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in the middle of a host write: no ack, everything back to reset values
        @(posedge clk); #1;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = ADDR_W'(500);
        host_wdata = 16'h5A5A;
        @(posedge clk); #1;
        check("midrst_mem_en", 32'(mem_en), 32'h1);
        check("midrst_mem_we", 32'(mem_we), 32'h1);
        rst      = 1'b1;
        host_req = 1'b0;
        #1;
        check("midrst_mem_en_clr", 32'(mem_en), 32'h0);
        check("midrst_underflow_clr", 32'(underflow), 32'h0);
        check("midrst_pix_valid_clr", 32'(pix_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_ack", 32'(host_ack), 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("refill_fetch_count", 32'(fetch_cnt), 32'(DEPTH));
        check("refill_pix_valid", 32'(pix_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
